corelet_seq: RTL and testbench
==============================

Name: corelet_seq

Overview:
- FSM that drives the 35-bit corelet instruction word for a full weight-stationary (WS) conv layer; supports an output-stationary (OS) variant.
- Per kernel position (kij), sequences:
  - weight fetch from activation/weight SRAM (xmem) into L0;
  - weight load into the MAC array;
  - pipeline flush;
  - activation fetch and execute;
  - OFIFO drain into psum SRAM (pmem).
- Sits between the top-level controller/testbench and the corelet + SRAMs; replaces hand-scripted instruction streams.

Parameters:
- row, 8, MAC array rows / L0 width in bw-lanes
- col, 8, MAC array columns
- num_kij, 9, kernel positions per layer
- len_nij, 36, activation vectors per kij pass
- addr_bw, 11, SRAM address width
- w_base, 11'd1024, xmem base address of weights (col words per kij)
- p_base, 11'd0, pmem base address of psums (len_nij words per kij)

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle pulse; starts a layer when in IDLE
- abort, in, 1, synchronous return to IDLE
- mode, in, 1, 0=WS, 1=OS; sampled on accepted start
- l0_full, in, 1, L0 full flag from corelet
- ofifo_valid, in, 1, OFIFO has a complete row
- inst, out, 35, corelet instruction word
- busy, out, 1, high in every state except IDLE
- done, out, 1, one-cycle pulse at layer completion
- kij_idx, out, 4, current kij (debug)

Behaviour:
- Clock/reset: one clock clk; reset asynchronous active-high.
  - On reset: state=IDLE, all counters 0.
  - inst = {1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0}, i.e. both CENs/WENs high (inactive), everything else 0.
  - busy=0, done=0.
- inst field map:
  - [34] mode; [33] acc (always 0 from this block)
  - [32] CEN_pmem, [31] WEN_pmem (active low); [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem (active low); [17:7] A_xmem
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd (both always 0)
  - [3] l0_rd, [2] l0_wr; [1] execute, [0] load
  - inst is fully registered. inst[34] equals the latched mode while busy, 0 in IDLE.
- SRAM read latency is 1 cycle: a read issued with CEN=0, WEN=1 at cycle t is paired with l0_wr=1 at cycle t+1.
- States and transitions:
  - IDLE: start=1 → W_FETCH in WS mode, A_FETCH in OS mode; kij=0, cnt=0.
  - W_FETCH: read xmem A = w_base + kij*col + cnt, cnt 0..col-1, with l0_wr trailing one cycle.
    - If l0_full=1, hold the read (CEN=1) and do not advance cnt.
    - After the last l0_wr → W_LOAD.
  - W_LOAD: l0_rd=1, load=1 for col cycles → W_FLUSH.
  - W_FLUSH: inst idle for row+col cycles → A_FETCH.
  - A_FETCH: read xmem A = cnt, cnt 0..len_nij-1, same pipelining and l0_full stall as W_FETCH → A_EXEC.
  - A_EXEC: l0_rd=1, execute=1 for len_nij cycles → DRAIN.
  - DRAIN: each cycle ofifo_valid=1 → ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = p_base + kij*len_nij + dcnt; dcnt++.
    - When dcnt reaches len_nij: if kij==num_kij-1 → DONE, else kij++ → W_FETCH (WS) or A_FETCH (OS).
  - DONE: done=1 for one cycle → IDLE.
- OS mode skips W_FETCH, W_LOAD and W_FLUSH; all other states are identical.
- start while busy is ignored.
- abort has priority over every transition:
  - next cycle: state=IDLE, inst at reset value;
  - done is not pulsed, and the pending l0_wr is dropped.
- Reset mid-operation: immediate asynchronous return to the reset values.
- Address arithmetic is modulo 2^addr_bw (wraps silently). Configurations overflowing SRAM are illegal and not checked.

Decomposition:
- Package corelet_pkg:
  - inst bit-position constants (INST_MODE=34 … INST_LOAD=0);
  - state encoding localparams;
  - IDLE_INST reset constant.
- One sub-module, sram_fetch_pipe: issues a counted xmem read stream with the 1-cycle-delayed l0_wr and l0_full stall. Reused by W_FETCH and A_FETCH.

Test Plan:
- WS, row=col=8, num_kij=1, len_nij=4, start=1 → 8 xmem reads at 1024..1031, l0_wr each one cycle later; 8 load cycles; 16 idle flush cycles; reads at 0..3; 4 execute cycles. With ofifo_valid forced 1: pmem writes at 0..3, then done 1 cycle, busy=0.
- num_kij=3, len_nij=4 → pmem addresses 0..11 in order, kij_idx 0→1→2; weight reads at 1024, 1032, 1040 bases.
- l0_full=1 for 3 cycles mid A_FETCH → CEN_xmem high and address held for 3 cycles; no duplicate or missing l0_wr; total l0_wr count = len_nij.
- ofifo_valid toggled 1,0,0,1,1,0,1 in DRAIN → ofifo_rd and pmem writes only in valid cycles; addresses contiguous.
- mode=1 start → first action is an xmem read at address 0 (no weight phase); inst[34]=1 throughout; done after num_kij*len_nij pmem writes.
- abort during A_EXEC, then reset asserted asynchronously mid W_LOAD → inst equals IDLE_INST the next cycle (abort) / immediately (reset); no done pulse; a subsequent start runs a clean full sequence.

Source files
------------

// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet instruction sequencer: instruction word
// layout, FSM state encoding and the idle instruction value.
package corelet_pkg;

  localparam int INST_W    = 35;
  localparam int ADDR_BW   = 11;
  localparam int CNT_W     = 8;
  localparam int KIJ_W     = 4;

  localparam int INST_MODE     = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_P    = 32;
  localparam int INST_WEN_P    = 31;
  localparam int INST_AP_HI    = 30;
  localparam int INST_AP_LO    = 20;
  localparam int INST_CEN_X    = 19;
  localparam int INST_WEN_X    = 18;
  localparam int INST_AX_HI    = 17;
  localparam int INST_AX_LO    = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXEC     = 1;
  localparam int INST_LOAD     = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_FETCH = 3'd1,
    ST_W_LOAD  = 3'd2,
    ST_W_FLUSH = 3'd3,
    ST_A_FETCH = 3'd4,
    ST_A_EXEC  = 3'd5,
    ST_DRAIN   = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Both SRAMs deselected (CEN/WEN high), every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST =
    {1'b0, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

endpackage

// File: rtl/corelet_seq_if.sv
// Control/status bundle between the layer controller and the corelet sequencer.
interface corelet_seq_if;
  import corelet_pkg::*;

  logic              start;
  logic              abort;
  logic              mode;
  logic              l0_full;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;
  logic [KIJ_W-1:0]  kij_idx;

  modport master (
    output start, abort, mode, l0_full, ofifo_valid,
    input  inst, busy, done, kij_idx
  );

  modport slave (
    input  start, abort, mode, l0_full, ofifo_valid,
    output inst, busy, done, kij_idx
  );
endinterface

// File: rtl/corelet_seq_sram_fetch_pipe.sv
// Counted xmem read stream into L0: one read per cycle unless L0 is full,
// with the matching l0_wr strobe trailing each read by the SRAM latency.
module sram_fetch_pipe
  import corelet_pkg::*;
#(
  parameter int addr_bw = ADDR_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               go,
  input  logic               l0_full,
  input  logic [addr_bw-1:0] base,
  input  logic [CNT_W-1:0]   len,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  output logic               l0_wr,
  output logic               last
);

  logic [CNT_W-1:0] cnt_r;
  logic             rd_r;
  logic             issue_s;

  assign issue_s = go && !l0_full && (cnt_r != len);
  assign rd_en   = issue_s;
  assign rd_addr = base + addr_bw'(cnt_r);
  assign l0_wr   = rd_r;
  assign last    = go && (cnt_r == len);

  // Read counter and one-cycle read-to-write delay stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_W'(0);
      rd_r  <= 1'b0;
    end else if (clr || !go) begin
      cnt_r <= CNT_W'(0);
      rd_r  <= 1'b0;
    end else begin
      rd_r <= issue_s;
      if (issue_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/corelet_seq.sv
// Layer sequencer: walks every kernel position through weight fetch/load,
// flush, activation fetch/execute and psum drain, emitting a registered inst.
module corelet_seq
  import corelet_pkg::*;
#(
  parameter int                 row     = 8,
  parameter int                 col     = 8,
  parameter int                 num_kij = 9,
  parameter int                 len_nij = 36,
  parameter int                 addr_bw = ADDR_BW,
  parameter logic [addr_bw-1:0] w_base  = 11'd1024,
  parameter logic [addr_bw-1:0] p_base  = 11'd0
) (
  input logic           clk,
  input logic           reset,
  corelet_seq_if.slave  bus
);

  localparam logic [addr_bw-1:0] COL_A = addr_bw'(col);
  localparam logic [addr_bw-1:0] LEN_A = addr_bw'(len_nij);

  state_t             state_r, state_s;
  logic [KIJ_W-1:0]   kij_r, kij_s, kij_out_r;
  logic [CNT_W-1:0]   ph_r, ph_s;
  logic               mode_r, mode_s;
  logic [INST_W-1:0]  inst_r, inst_s;
  logic               busy_r, done_r;
  logic [addr_bw-1:0] kij_a_s, fp_base_s, fp_addr_s, p_addr_s;
  logic [CNT_W-1:0]   fp_len_s;
  logic               fp_go_s, fp_rd_s, fp_l0wr_s, fp_last_s;

  assign kij_a_s   = addr_bw'(kij_r);
  assign fp_go_s   = (state_r == ST_W_FETCH) || (state_r == ST_A_FETCH);
  assign fp_base_s = (state_r == ST_W_FETCH) ? w_base + kij_a_s * COL_A : addr_bw'(0);
  assign fp_len_s  = (state_r == ST_W_FETCH) ? CNT_W'(col) : CNT_W'(len_nij);
  assign p_addr_s  = p_base + kij_a_s * LEN_A + addr_bw'(ph_r);

  sram_fetch_pipe #(.addr_bw(addr_bw)) u_fetch (
    .clk     (clk),
    .reset   (reset),
    .clr     (bus.abort),
    .go      (fp_go_s),
    .l0_full (bus.l0_full),
    .base    (fp_base_s),
    .len     (fp_len_s),
    .rd_en   (fp_rd_s),
    .rd_addr (fp_addr_s),
    .l0_wr   (fp_l0wr_s),
    .last    (fp_last_s)
  );

  // Next state, kernel index and latched mode; abort overrides everything.
  always_comb begin
    state_s = state_r;
    kij_s   = kij_r;
    mode_s  = mode_r;
    if (bus.abort) begin
      state_s = ST_IDLE;
      kij_s   = KIJ_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            mode_s  = bus.mode;
            kij_s   = KIJ_W'(0);
            state_s = bus.mode ? ST_A_FETCH : ST_W_FETCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_W_FETCH: state_s = fp_last_s ? ST_W_LOAD : ST_W_FETCH;
        ST_W_LOAD:  state_s = (ph_r == CNT_W'(col - 1)) ? ST_W_FLUSH : ST_W_LOAD;
        ST_W_FLUSH: state_s = (ph_r == CNT_W'(row + col - 1)) ? ST_A_FETCH : ST_W_FLUSH;
        ST_A_FETCH: state_s = fp_last_s ? ST_A_EXEC : ST_A_FETCH;
        ST_A_EXEC:  state_s = (ph_r == CNT_W'(len_nij - 1)) ? ST_DRAIN : ST_A_EXEC;
        ST_DRAIN: begin
          if (bus.ofifo_valid && (ph_r == CNT_W'(len_nij - 1))) begin
            if (kij_r == KIJ_W'(num_kij - 1)) begin
              state_s = ST_DONE;
            end else begin
              kij_s   = kij_r + KIJ_W'(1);
              state_s = mode_r ? ST_A_FETCH : ST_W_FETCH;
            end
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
          kij_s   = KIJ_W'(0);
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Phase counter: restarts on every state change; in DRAIN it counts writes.
  always_comb begin
    ph_s = ph_r;
    if (state_s != state_r) begin
      ph_s = CNT_W'(0);
    end else if (state_r == ST_IDLE) begin
      ph_s = CNT_W'(0);
    end else if (state_r == ST_DRAIN) begin
      ph_s = ph_r + CNT_W'(bus.ofifo_valid);
    end else begin
      ph_s = ph_r + CNT_W'(1);
    end
  end

  // Instruction word for the current state, registered on the next edge.
  always_comb begin
    inst_s = IDLE_INST;
    if (!bus.abort) begin
      inst_s[INST_MODE] = (state_r != ST_IDLE) ? mode_r : 1'b0;
      case (state_r)
        ST_W_FETCH, ST_A_FETCH: begin
          inst_s[INST_CEN_X]              = ~fp_rd_s;
          inst_s[INST_AX_HI:INST_AX_LO]   = fp_addr_s;
          inst_s[INST_L0_WR]              = fp_l0wr_s;
        end
        ST_W_LOAD: begin
          inst_s[INST_L0_RD] = 1'b1;
          inst_s[INST_LOAD]  = 1'b1;
        end
        ST_A_EXEC: begin
          inst_s[INST_L0_RD] = 1'b1;
          inst_s[INST_EXEC]  = 1'b1;
        end
        ST_DRAIN: begin
          if (bus.ofifo_valid) begin
            inst_s[INST_OFIFO_RD]         = 1'b1;
            inst_s[INST_CEN_P]            = 1'b0;
            inst_s[INST_WEN_P]            = 1'b0;
            inst_s[INST_AP_HI:INST_AP_LO] = p_addr_s;
          end else begin
            inst_s[INST_OFIFO_RD] = 1'b0;
          end
        end
        default: inst_s[INST_ACC] = 1'b0;
      endcase
    end else begin
      inst_s = IDLE_INST;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      kij_r     <= KIJ_W'(0);
      ph_r      <= CNT_W'(0);
      mode_r    <= 1'b0;
      inst_r    <= IDLE_INST;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      kij_out_r <= KIJ_W'(0);
    end else begin
      state_r   <= state_s;
      kij_r     <= kij_s;
      ph_r      <= ph_s;
      mode_r    <= mode_s;
      inst_r    <= inst_s;
      busy_r    <= !bus.abort && (state_r != ST_IDLE);
      done_r    <= !bus.abort && (state_r == ST_DONE);
      kij_out_r <= bus.abort ? KIJ_W'(0) : kij_r;
    end
  end

  assign bus.inst    = inst_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.kij_idx = kij_out_r;

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: expected xmem/pmem addresses are queued
// per layer and matched against the instruction stream as it appears.
module tb_corelet_seq;
  import corelet_pkg::*;

  localparam int ROW = 8, COL = 8, NK = 3, LEN = 4;
  localparam int W_BASE = 1024, P_BASE = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  corelet_seq_if bus ();

  corelet_seq #(
    .row(ROW), .col(COL), .num_kij(NK), .len_nij(LEN), .addr_bw(11),
    .w_base(11'd1024), .p_base(11'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0, n_errors = 0;
  int xq[$], pq[$];
  bit sb_on = 0, pat_on = 0, exp_mode = 0, prev_xrd = 0, gap_arm = 0;
  int stall_arm = 0, full_cnt = 0, vidx = 0;
  int n_load, n_exec, n_done = 0, mode_bad, idle_bad, gap, hold_cnt;
  bit vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor_cycle();
    logic [INST_W-1:0] i;
    bit xrd, pwr;
    int e;
    i   = bus.inst;
    xrd = !i[INST_CEN_X] && i[INST_WEN_X];
    pwr = !i[INST_CEN_P] && !i[INST_WEN_P];
    if (xrd) begin
      e = (xq.size() != 0) ? xq.pop_front() : -1;
      check_eq("xmem_addr", i[INST_AX_HI:INST_AX_LO], e);
    end
    if (i[INST_L0_WR] || prev_xrd) check_eq("l0_wr_pair", i[INST_L0_WR], prev_xrd);
    prev_xrd = xrd;
    if (pwr || i[INST_OFIFO_RD]) begin
      e = (pq.size() != 0) ? pq.pop_front() : -1;
      check_eq("pmem_addr", i[INST_AP_HI:INST_AP_LO], e);
      check_eq("ofifo_rd", i[INST_OFIFO_RD], pwr);
      check_eq("wr_needs_valid", bus.ofifo_valid, 1);
      if (e >= 0) check_eq("kij_idx", bus.kij_idx, (e - P_BASE) / LEN);
    end
    if (i[INST_LOAD]) begin
      n_load++;
      gap = 0;
      gap_arm = 1;
    end else if (gap_arm && xrd) begin
      check_eq("flush_gap", gap, ROW + COL);
      gap_arm = 0;
    end else if (gap_arm) begin
      gap++;
    end
    if (i[INST_EXEC]) n_exec++;
    if (i[INST_ACC] || i[INST_IFIFO_WR] || i[INST_IFIFO_RD]) idle_bad++;
    if (i[INST_L0_RD] != (i[INST_LOAD] || i[INST_EXEC])) idle_bad++;
    if (bus.busy && i[INST_MODE] != exp_mode) mode_bad++;
    if (!bus.busy && i !== IDLE_INST) idle_bad++;
    if (i[INST_CEN_X] && i[INST_AX_HI:INST_AX_LO] == 11'd2) hold_cnt++;
    if (stall_arm != 0 && xrd && i[INST_AX_HI:INST_AX_LO] == 11'd1) begin
      full_cnt  = 3;
      stall_arm = 0;
    end
    if (bus.done) begin
      n_done++;
      check_eq("done_xq_empty", xq.size(), 0);
      check_eq("done_pq_empty", pq.size(), 0);
    end
  endtask

  // Monitor at negedge, then drive the corelet-side status inputs.
  initial begin
    bus.ofifo_valid = 1'b1;
    bus.l0_full     = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_on) monitor_cycle();
      else prev_xrd = 0;
      bus.l0_full = (full_cnt > 0);
      if (full_cnt > 0) full_cnt--;
      if (pat_on) begin
        bus.ofifo_valid = vpat[vidx];
        vidx = (vidx + 1) % 7;
      end else begin
        bus.ofifo_valid = 1'b1;
      end
    end
  end

  task automatic run_layer(input bit m, input bit pat, input bit stall);
    int d0, c;
    xq.delete();
    pq.delete();
    for (int k = 0; k < NK; k++) begin
      if (!m) for (int j = 0; j < COL; j++) xq.push_back(W_BASE + k * COL + j);
      for (int j = 0; j < LEN; j++) xq.push_back(j);
      for (int j = 0; j < LEN; j++) pq.push_back(P_BASE + k * LEN + j);
    end
    n_load = 0; n_exec = 0; mode_bad = 0; idle_bad = 0; hold_cnt = 0;
    gap_arm = 0; exp_mode = m; pat_on = pat; vidx = 0; stall_arm = stall;
    sb_on = 1;
    d0 = n_done;
    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.mode  = !m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = m;
    c = 0;
    while (n_done == d0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    check_eq("done_seen", n_done - d0, 1);
    @(negedge clk);
    check_eq("busy_after_done", bus.busy, 0);
    repeat (4) @(negedge clk);
    check_eq("done_once", n_done - d0, 1);
    check_eq("load_cycles", n_load, m ? 0 : NK * COL);
    check_eq("exec_cycles", n_exec, NK * LEN);
    check_eq("mode_bit", mode_bad, 0);
    check_eq("idle_fields", idle_bad, 0);
    if (stall) check_eq("stall_hold", hold_cnt, 3);
    sb_on = 0;
    pat_on = 0;
  endtask

  initial begin
    int c, dcnt, bad;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_inst", bus.inst, IDLE_INST);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_kij", bus.kij_idx, 0);
    reset = 1'b0;
    @(negedge clk);

    run_layer(1'b0, 1'b0, 1'b0);
    run_layer(1'b0, 1'b1, 1'b0);
    run_layer(1'b1, 1'b0, 1'b1);

    // abort during A_EXEC
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 0;
    while (!bus.inst[INST_EXEC] && c < 500) begin
      @(negedge clk);
      c++;
    end
    check_eq("reach_exec", bus.inst[INST_EXEC], 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_inst", bus.inst, IDLE_INST);
    check_eq("abort_busy", bus.busy, 0);
    dcnt = 0;
    bad  = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) dcnt++;
      if (bus.inst !== IDLE_INST || bus.busy) bad++;
    end
    check_eq("abort_no_done", dcnt, 0);
    check_eq("abort_stays_idle", bad, 0);

    // asynchronous reset during W_LOAD
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 0;
    while (!bus.inst[INST_LOAD] && c < 500) begin
      @(negedge clk);
      c++;
    end
    check_eq("reach_load", bus.inst[INST_LOAD], 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_inst", bus.inst, IDLE_INST);
    check_eq("arst_busy", bus.busy, 0);
    check_eq("arst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_layer(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
